// File: rtl/clk_pkg.sv
// Shared constants and helpers for the clock counter/meter family.
package clk_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } meter_state_t;

  // Largest value representable in 'width' bits; width 32 yields all-ones.
  function automatic logic [31:0] cnt_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronises an asynchronous input and flags its rising edges for one cycle.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   dly;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      dly  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      dly  <= sync[SYNC_STAGES-1];
    end
  end

  assign rise = sync[SYNC_STAGES-1] & ~dly;

endmodule

// File: rtl/clk_period_meter.sv
// Measures clk cycles between successive rising edges of sig_in and
// presents each result through a one-entry valid/ready output register.
module clk_period_meter
  import clk_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sig_in,
  output logic [COUNT_WIDTH-1:0] period,
  output logic                   ovf,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   dropped
);

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = COUNT_WIDTH'(cnt_max(COUNT_WIDTH));
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  meter_state_t           state, state_nxt;
  logic                   rise;
  logic [COUNT_WIDTH-1:0] cnt, cnt_nxt;
  logic                   sat, sat_nxt;
  logic                   capture;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (sig_in),
    .rise (rise)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_IDLE && rise) state_nxt = ST_MEASURE;
  end

  // sat is raised only when the count would have gone past CNT_MAX, so an
  // interval of exactly CNT_MAX cycles still reports without ovf.
  always_comb begin
    cnt_nxt = cnt;
    sat_nxt = sat;
    capture = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cnt_nxt = rise ? CNT_ONE : '0;
        sat_nxt = 1'b0;
      end
      ST_MEASURE: begin
        if (rise) begin
          capture = 1'b1;
          cnt_nxt = CNT_ONE;
          sat_nxt = 1'b0;
        end else if (cnt == CNT_MAX) begin
          sat_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      sat       <= 1'b0;
      period    <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      sat <= sat_nxt;
      if (capture) begin
        period    <= cnt;
        ovf       <= sat;
        out_valid <= 1'b1;
        if (out_valid && !out_ready) dropped <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Randomised bench for clk_period_meter: two widths driven in parallel and
// compared every cycle against a timestamp-based reference model.
module tb_clk_period_meter;

  localparam int unsigned SS = 2;
  localparam int          NC = 8192;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sig_in = 1'b0;
  logic        out_ready = 1'b0;

  logic [15:0] period_a;
  logic        ovf_a, valid_a, dropped_a;
  logic [3:0]  period_b;
  logic        ovf_b, valid_b, dropped_b;

  clk_period_meter #(.COUNT_WIDTH(16), .SYNC_STAGES(SS)) dut_a (
    .clk(clk), .rst(rst), .sig_in(sig_in), .period(period_a), .ovf(ovf_a),
    .out_valid(valid_a), .out_ready(out_ready), .dropped(dropped_a)
  );

  clk_period_meter #(.COUNT_WIDTH(4), .SYNC_STAGES(SS)) dut_b (
    .clk(clk), .rst(rst), .sig_in(sig_in), .period(period_b), .ovf(ovf_b),
    .out_valid(valid_b), .out_ready(out_ready), .dropped(dropped_b)
  );

  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned fails = 0;

  // Input history per clock edge, and reference model state.
  bit  sig_h [NC];
  bit  rst_h [NC];
  int  cyc = 0;
  bit  armed = 1'b0;
  int  last = 0;
  bit  m_valid = 1'b0;
  bit  m_drop = 1'b0;
  int  m_per [2] = '{0, 0};
  bit  m_ovf [2] = '{1'b0, 1'b0};
  int  mx    [2] = '{65535, 15};

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Level seen at the synchroniser output after edge e.
  function automatic bit syn(input int e);
    if (e < int'(SS) - 1) return 1'b0;
    for (int k = e - int'(SS) + 1; k <= e; k++)
      if (rst_h[k]) return 1'b0;
    return sig_h[e - int'(SS) + 1];
  endfunction

  task automatic model_step(input bit r);
    bit e;
    bit cap;
    int n;
    if (rst_h[cyc]) begin
      armed   = 1'b0;
      m_valid = 1'b0;
      m_drop  = 1'b0;
      m_per   = '{0, 0};
      m_ovf   = '{1'b0, 1'b0};
    end else begin
      e   = syn(cyc - 1) && !syn(cyc - 2);
      cap = 1'b0;
      n   = 0;
      if (e) begin
        if (armed) begin
          cap = 1'b1;
          n   = cyc - last;
        end
        armed = 1'b1;
        last  = cyc;
      end
      if (cap) begin
        if (m_valid && !r) m_drop = 1'b1;
        for (int d = 0; d < 2; d++) begin
          m_per[d] = (n > mx[d]) ? mx[d] : n;
          m_ovf[d] = (n > mx[d]);
        end
        m_valid = 1'b1;
      end else if (m_valid && r) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic tick(input bit s, input bit r, input bit rs);
    if (cyc >= NC) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", cyc, NC);
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1);
    end
    @(negedge clk);
    sig_in    = s;
    out_ready = r;
    rst       = rs;
    @(posedge clk);
    sig_h[cyc] = s;
    rst_h[cyc] = rs;
    model_step(r);
    #1;
    check("valid_a",   valid_a,   m_valid);
    check("valid_b",   valid_b,   m_valid);
    check("dropped_a", dropped_a, m_drop);
    check("dropped_b", dropped_b, m_drop);
    check("period_a",  period_a,  m_per[0]);
    check("period_b",  period_b,  m_per[1]);
    check("ovf_a",     ovf_a,     m_ovf[0]);
    check("ovf_b",     ovf_b,     m_ovf[1]);
    cyc++;
  endtask

  // n periods of length p, each a high pulse of random width; rmode 0/1 fixes
  // out_ready, 2 randomises it per cycle.
  task automatic train(input int p, input int n, input int rmode);
    int w;
    bit r;
    for (int i = 0; i < n; i++) begin
      w = $urandom_range(p - 1, 1);
      for (int j = 0; j < p; j++) begin
        r = (rmode == 2) ? bit'($urandom_range(1, 0)) : bit'(rmode);
        tick(j < w, r, 1'b0);
      end
    end
  endtask

  initial begin
    repeat (3) tick(1'b0, 1'b0, 1'b1);
    repeat (4) tick(1'b0, 1'b1, 1'b0);

    train(10, 8, 1);
    train(20, 2, 1);
    train(5, 3, 1);

    for (int i = 0; i < 60; i++) train($urandom_range(25, 2), 1, 2);

    train(8, 4, 0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);

    train(3, 6, 1);

    train(12, 1, 1);
    repeat (4) tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    train(12, 3, 1);

    train(2, 6, 1);
    train(16, 2, 1);
    train(15, 2, 1);

    tick(1'b0, 1'b1, 1'b1);
    repeat (1000) tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    repeat (300) tick(1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
